// File: rtl/fsm_step5_pkg.sv
// Shared definitions for the step-5 writeback/exception stage: opcodes, cause
// codes, exception vector and FSM state encoding.
package fsm_step5_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_ERET  = 6'h10;

  localparam logic [31:0] INTERRUPTS_ADDR = 32'h0000_0080;

  typedef enum logic [2:0] {
    CAUSE_IRQ      = 3'b000,
    CAUSE_SYSCALL  = 3'b001,
    CAUSE_ILLEGAL  = 3'b010,
    CAUSE_OVERFLOW = 3'b011,
    CAUSE_NONE     = 3'b111
  } cause_e;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_SAVE    = 3'd1,
    ST_VECTOR  = 3'd2,
    ST_HANDLER = 3'd3,
    ST_RETURN  = 3'd4
  } state_e;

  // Reserved codes 100-110 fold into ILLEGAL.
  function automatic cause_e norm_cause(input logic [2:0] c);
    case (c)
      3'b000:  return CAUSE_IRQ;
      3'b001:  return CAUSE_SYSCALL;
      3'b011:  return CAUSE_OVERFLOW;
      3'b111:  return CAUSE_NONE;
      default: return CAUSE_ILLEGAL;
    endcase
  endfunction

  // IRQ and SYSCALL resume after the instruction; faults re-execute it.
  function automatic logic saves_next_pc(input cause_e c);
    return (c == CAUSE_IRQ) || (c == CAUSE_SYSCALL);
  endfunction

endpackage

// File: rtl/fsm_step5_if.sv
// Step-4 to step-5 bundle plus register-file, CP0 status and fetch redirect.
interface fsm_step5_if;
  logic        valid_step4;
  logic        flush_step4;
  logic [5:0]  opcode;
  logic [2:0]  cause_step4;
  logic [31:0] pc_step4;
  logic [4:0]  rd_addr;
  logic [31:0] wb_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] epc;
  logic [2:0]  cause;
  logic        ie;
  logic        double_fault;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        redirect_ack;
  logic        stall_up;

  modport slave (
    input  valid_step4, flush_step4, opcode, cause_step4, pc_step4, rd_addr,
           wb_data, redirect_ack,
    output rf_we, rf_waddr, rf_wdata, epc, cause, ie, double_fault,
           redirect, redirect_pc, stall_up
  );

  modport master (
    output valid_step4, flush_step4, opcode, cause_step4, pc_step4, rd_addr,
           wb_data, redirect_ack,
    input  rf_we, rf_waddr, rf_wdata, epc, cause, ie, double_fault,
           redirect, redirect_pc, stall_up
  );
endinterface

// File: rtl/fsm_step5_cp0_regs.sv
// CP0 storage: exception PC, cause, interrupt enable and sticky double-fault.
module cp0_regs
  import fsm_step5_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        save_en,
  input  logic [31:0] save_pc,
  input  cause_e      save_code,
  input  logic        ie_set,
  input  logic        df_set,
  output logic [31:0] epc,
  output logic [2:0]  cause,
  output logic        ie,
  output logic        double_fault
);

  logic [31:0] epc_q, epc_d;
  cause_e      cause_q, cause_d;
  logic        ie_q, ie_d;
  logic        df_q, df_d;

  always_comb begin
    epc_d   = epc_q;
    cause_d = cause_q;
    ie_d    = ie_q;
    df_d    = df_q;
    if (save_en) begin
      // 32-bit add wraps naturally, so 0xFFFFFFFC resumes at 0.
      epc_d   = saves_next_pc(save_code) ? save_pc + 32'd4 : save_pc;
      cause_d = save_code;
      ie_d    = 1'b0;
    end
    if (ie_set) ie_d = 1'b1;
    if (df_set) df_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      epc_q   <= 32'd0;
      cause_q <= CAUSE_NONE;
      ie_q    <= 1'b1;
      df_q    <= 1'b0;
    end else begin
      epc_q   <= epc_d;
      cause_q <= cause_d;
      ie_q    <= ie_d;
      df_q    <= df_d;
    end
  end

  assign epc          = epc_q;
  assign cause        = cause_q;
  assign ie           = ie_q;
  assign double_fault = df_q;

endmodule

// File: rtl/fsm_step5.sv
// Step-5: register-file writeback and exception entry/return sequencing
// (RUN -> SAVE -> VECTOR -> HANDLER -> RETURN -> RUN).
module fsm_step5
  import fsm_step5_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  fsm_step5_if.slave bus
);

  state_e      state_q, state_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  cause_e      pend_code_q, pend_code_d;

  logic        accepted, is_eret, plain;
  cause_e      code;
  logic        wb_en, save_en, ie_set, df_set, redirect, stall_up;
  logic [31:0] redirect_pc;
  logic [31:0] epc_w;
  logic [2:0]  cause_w;
  logic        ie_w, df_w;

  assign accepted = bus.valid_step4 & ~bus.flush_step4;
  assign code     = norm_cause(bus.cause_step4);
  assign is_eret  = (bus.opcode == OP_ERET);
  assign plain    = (code == CAUSE_NONE) && !is_eret;

  always_comb begin
    state_d     = state_q;
    pend_pc_d   = pend_pc_q;
    pend_code_d = pend_code_q;
    wb_en       = 1'b0;
    save_en     = 1'b0;
    ie_set      = 1'b0;
    df_set      = 1'b0;
    redirect    = 1'b0;
    redirect_pc = INTERRUPTS_ADDR;
    stall_up    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (accepted) begin
          // An interrupted instruction still completes its writeback.
          wb_en = plain || (code == CAUSE_IRQ);
          if (!plain && ie_w) begin
            pend_pc_d   = bus.pc_step4;
            pend_code_d = (code == CAUSE_NONE) ? CAUSE_ILLEGAL : code;
            state_d     = ST_SAVE;
          end
        end
      end
      ST_SAVE: begin
        save_en  = 1'b1;
        stall_up = 1'b1;
        state_d  = ST_VECTOR;
      end
      ST_VECTOR: begin
        redirect = 1'b1;
        stall_up = 1'b1;
        if (bus.redirect_ack) state_d = ST_HANDLER;
      end
      ST_HANDLER: begin
        if (accepted) begin
          if (code == CAUSE_NONE || code == CAUSE_IRQ) begin
            if (is_eret) state_d = ST_RETURN;
            else         wb_en   = 1'b1;
          end else begin
            df_set = 1'b1;
          end
        end
      end
      ST_RETURN: begin
        redirect    = 1'b1;
        redirect_pc = epc_w;
        stall_up    = 1'b1;
        if (bus.redirect_ack) begin
          ie_set  = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Trap PC/code only matter once SAVE is entered, so they carry no reset.
  always_ff @(posedge clk) begin
    pend_pc_q   <= pend_pc_d;
    pend_code_q <= pend_code_d;
  end

  cp0_regs u_cp0 (
    .clk          (clk),
    .reset        (reset),
    .save_en      (save_en),
    .save_pc      (pend_pc_q),
    .save_code    (pend_code_q),
    .ie_set       (ie_set),
    .df_set       (df_set),
    .epc          (epc_w),
    .cause        (cause_w),
    .ie           (ie_w),
    .double_fault (df_w)
  );

  assign bus.rf_we        = wb_en && (bus.rd_addr != 5'd0) && reset;
  assign bus.rf_waddr     = bus.rd_addr;
  assign bus.rf_wdata     = bus.wb_data;
  assign bus.epc          = epc_w;
  assign bus.cause        = cause_w;
  assign bus.ie           = ie_w;
  assign bus.double_fault = df_w;
  assign bus.redirect     = redirect;
  assign bus.redirect_pc  = redirect_pc;
  assign bus.stall_up     = stall_up;

endmodule

// File: tb/tb_fsm_step5.sv
// Directed bench for fsm_step5: writeback scoreboard plus exception-sequence checks.
module tb_fsm_step5;
  import fsm_step5_pkg::*;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
  } wb_t;
  wb_t sb_q[$];

  fsm_step5_if bus ();
  fsm_step5 dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.valid_step4  = 1'b0;
    bus.flush_step4  = 1'b0;
    bus.redirect_ack = 1'b0;
    bus.opcode       = OP_RTYPE;
    bus.cause_step4  = CAUSE_NONE;
    bus.pc_step4     = 32'd0;
    bus.rd_addr      = 5'd0;
    bus.wb_data      = 32'd0;
  endtask

  // Advance to 1 ns after the next rising edge and release one-cycle inputs.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  // Drive one step-4 instruction and record the writeback it must produce.
  task automatic inst(input logic fl, input logic [5:0] op, input logic [2:0] cs,
                      input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] data,
                      input logic exp_we);
    wb_t e;
    bus.valid_step4 = 1'b1;
    bus.flush_step4 = fl;
    bus.opcode      = op;
    bus.cause_step4 = cs;
    bus.pc_step4    = pc;
    bus.rd_addr     = rd;
    bus.wb_data     = data;
    e.we = exp_we;
    e.a  = rd;
    e.d  = data;
    sb_q.push_back(e);
    #1;
  endtask

  task automatic sb_check(input string tag);
    wb_t e;
    e = sb_q.pop_front();
    chk({tag, ".rf_we"}, {31'd0, bus.rf_we}, {31'd0, e.we});
    if (e.we) begin
      chk({tag, ".rf_waddr"}, {27'd0, bus.rf_waddr}, {27'd0, e.a});
      chk({tag, ".rf_wdata"}, bus.rf_wdata, e.d);
    end
  endtask

  initial begin
    clk   = 1'b0;
    reset = 1'b1;
    idle();
    #2 reset = 1'b0;
    // Writeback must be gated even with a valid instruction during reset.
    inst(1'b0, OP_RTYPE, CAUSE_NONE, 32'h10, 5'd5, 32'h1234, 1'b0);
    sb_check("rst_wb");
    chk("rst.redirect", {31'd0, bus.redirect}, 32'd0);
    chk("rst.stall_up", {31'd0, bus.stall_up}, 32'd0);
    chk("rst.epc", bus.epc, 32'd0);
    chk("rst.cause", {29'd0, bus.cause}, 32'd7);
    chk("rst.ie", {31'd0, bus.ie}, 32'd1);
    chk("rst.df", {31'd0, bus.double_fault}, 32'd0);
    tick();
    reset = 1'b1;

    inst(1'b0, OP_RTYPE, CAUSE_NONE, 32'h10, 5'd5, 32'h1234, 1'b1);
    sb_check("add_rd5");
    tick();
    inst(1'b0, OP_RTYPE, CAUSE_NONE, 32'h14, 5'd0, 32'h5678, 1'b0);
    sb_check("add_rd0");
    chk("run.stall_up", {31'd0, bus.stall_up}, 32'd0);
    tick();

    inst(1'b1, OP_RTYPE, CAUSE_SYSCALL, 32'h40, 5'd7, 32'h99, 1'b0);
    sb_check("flush");
    tick();
    chk("flush.stall_up", {31'd0, bus.stall_up}, 32'd0);
    chk("flush.redirect", {31'd0, bus.redirect}, 32'd0);
    chk("flush.ie", {31'd0, bus.ie}, 32'd1);
    bus.redirect_ack = 1'b1;
    #1 chk("ack_run.redirect", {31'd0, bus.redirect}, 32'd0);
    tick();
    inst(1'b0, OP_ADDI, CAUSE_NONE, 32'h18, 5'd6, 32'h77, 1'b1);
    sb_check("after_ack");
    tick();

    inst(1'b0, OP_RTYPE, CAUSE_SYSCALL, 32'h40, 5'd7, 32'haa, 1'b0);
    sb_check("syscall");
    tick();
    chk("save.stall_up", {31'd0, bus.stall_up}, 32'd1);
    chk("save.redirect", {31'd0, bus.redirect}, 32'd0);
    tick();
    chk("sys.epc", bus.epc, 32'h44);
    chk("sys.cause", {29'd0, bus.cause}, 32'd1);
    chk("sys.ie", {31'd0, bus.ie}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("vec.redirect", {31'd0, bus.redirect}, 32'd1);
      chk("vec.redirect_pc", bus.redirect_pc, 32'h80);
      chk("vec.stall_up", {31'd0, bus.stall_up}, 32'd1);
      if (i == 2) bus.redirect_ack = 1'b1;
      tick();
    end
    chk("hnd.redirect", {31'd0, bus.redirect}, 32'd0);
    chk("hnd.stall_up", {31'd0, bus.stall_up}, 32'd0);

    inst(1'b0, OP_RTYPE, CAUSE_OVERFLOW, 32'h90, 5'd9, 32'h11, 1'b0);
    sb_check("hnd_ovf");
    tick();
    chk("ovf.df", {31'd0, bus.double_fault}, 32'd1);
    chk("ovf.epc", bus.epc, 32'h44);
    chk("ovf.cause", {29'd0, bus.cause}, 32'd1);
    inst(1'b0, OP_LW, CAUSE_IRQ, 32'h94, 5'd4, 32'h55, 1'b1);
    sb_check("hnd_irq");
    tick();
    chk("hirq.epc", bus.epc, 32'h44);
    chk("hirq.redirect", {31'd0, bus.redirect}, 32'd0);
    inst(1'b0, OP_ERET, CAUSE_NONE, 32'h98, 5'd1, 32'h0, 1'b0);
    sb_check("hnd_eret");
    tick();
    chk("ret.redirect", {31'd0, bus.redirect}, 32'd1);
    chk("ret.redirect_pc", bus.redirect_pc, 32'h44);
    chk("ret.stall_up", {31'd0, bus.stall_up}, 32'd1);
    bus.redirect_ack = 1'b1;
    tick();
    chk("back.ie", {31'd0, bus.ie}, 32'd1);
    chk("back.redirect", {31'd0, bus.redirect}, 32'd0);
    chk("back.df_sticky", {31'd0, bus.double_fault}, 32'd1);

    inst(1'b0, OP_RTYPE, CAUSE_IRQ, 32'h100, 5'd3, 32'habc, 1'b1);
    sb_check("run_irq");
    tick();
    tick();
    chk("irq.epc", bus.epc, 32'h104);
    chk("irq.cause", {29'd0, bus.cause}, 32'd0);
    bus.redirect_ack = 1'b1;
    tick();
    inst(1'b0, OP_ERET, CAUSE_NONE, 32'h180, 5'd0, 32'h0, 1'b0);
    sb_check("irq_eret");
    tick();
    chk("irq_ret.redirect_pc", bus.redirect_pc, 32'h104);
    bus.redirect_ack = 1'b1;
    tick();
    chk("irq_back.ie", {31'd0, bus.ie}, 32'd1);
    chk("irq_back.stall_up", {31'd0, bus.stall_up}, 32'd0);

    inst(1'b0, OP_ERET, CAUSE_NONE, 32'h200, 5'd2, 32'h0, 1'b0);
    sb_check("run_eret");
    tick();
    tick();
    chk("eret_run.cause", {29'd0, bus.cause}, 32'd2);
    chk("eret_run.epc", bus.epc, 32'h200);
    chk("eret_run.redirect", {31'd0, bus.redirect}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rstvec.redirect", {31'd0, bus.redirect}, 32'd0);
    chk("rstvec.stall_up", {31'd0, bus.stall_up}, 32'd0);
    chk("rstvec.cause", {29'd0, bus.cause}, 32'd7);
    chk("rstvec.ie", {31'd0, bus.ie}, 32'd1);
    chk("rstvec.df", {31'd0, bus.double_fault}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst.redirect", {31'd0, bus.redirect}, 32'd0);
    chk("post_rst.ie", {31'd0, bus.ie}, 32'd1);
    chk("post_rst.cause", {29'd0, bus.cause}, 32'd7);
    inst(1'b0, OP_RTYPE, CAUSE_NONE, 32'h20, 5'd8, 32'hbeef, 1'b1);
    sb_check("post_rst_wb");
    tick();

    inst(1'b0, OP_RTYPE, 3'b101, 32'h300, 5'd8, 32'h1, 1'b0);
    sb_check("rsvd_cause");
    tick();
    tick();
    chk("rsvd.cause", {29'd0, bus.cause}, 32'd2);
    chk("rsvd.epc", bus.epc, 32'h300);
    reset = 1'b0;
    #1 reset = 1'b1;
    tick();

    inst(1'b0, OP_RTYPE, CAUSE_IRQ, 32'hFFFF_FFFC, 5'd0, 32'h2, 1'b0);
    sb_check("wrap_irq");
    tick();
    tick();
    chk("wrap.epc", bus.epc, 32'h0);
    chk("wrap.cause", {29'd0, bus.cause}, 32'd0);
    chk("wrap.redirect", {31'd0, bus.redirect}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fsm_step5.md
FSM_STEP5 -- requirements
Module: fsm_step5

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state on rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately.
REQ-003 SHALL have port: valid_step4  in  1  step-4 result valid this cycle.
REQ-004 SHALL have port: flush_step4  in  1  squash; the step-4 result this cycle is ignored.
REQ-005 SHALL have port: opcode  in  6  instruction opcode from step 4.
REQ-006 SHALL have port: cause_step4  in  3  exception cause from step 4.
REQ-007 SHALL have ports: pc_step4 in 32 (instruction PC); rd_addr in 5; wb_data in 32 (ALU or load result).
REQ-008 SHALL have ports: rf_we out 1; rf_waddr out 5; rf_wdata out 32 (register-file write).
REQ-009 SHALL have ports: epc out 32; cause out 3; ie out 1 (interrupt enable); double_fault out 1 (sticky).
REQ-010 SHALL have ports: redirect out 1; redirect_pc out 32; redirect_ack in 1 (fetch accepts the new PC).
REQ-011 SHALL have port: stall_up out 1; when high, steps 1-4 hold.

Function
REQ-012 Cause codes: 000 IRQ, 001 SYSCALL, 010 ILLEGAL, 011 OVERFLOW, 111 NONE; 100-110 SHALL be treated as ILLEGAL.
REQ-013 An accepted instruction SHALL be valid_step4=1 and flush_step4=0; no other input is sampled when none is accepted.
REQ-014 FSM states SHALL be RUN, SAVE, VECTOR, HANDLER, RETURN.
REQ-015 RUN/HANDLER with an accepted instruction of cause NONE and opcode other than ERET: rf_we=1 in the same cycle (combinational), unless rd_addr=0; latency 0.
REQ-016 RUN with an accepted instruction, cause!=NONE and ie=1 -> SAVE; rf_we=1 only for IRQ (the instruction completes).
REQ-017 SAVE, one cycle: epc<=pc_step4+4 for IRQ/SYSCALL, else epc<=pc_step4; cause<=code; ie<=0; stall_up=1; -> VECTOR.
REQ-018 VECTOR: redirect=1, redirect_pc=INTERRUPTS_ADDR, stall_up=1; held until redirect_ack=1, then -> HANDLER.
REQ-019 HANDLER: writeback per REQ-015; accepted IRQ cause is ignored and the instruction is written back normally.
REQ-020 HANDLER: accepted non-IRQ cause -> double_fault<=1, instruction dropped, state unchanged, epc/cause unchanged.
REQ-021 HANDLER with an accepted ERET (cause NONE) -> RETURN; no register write.
REQ-022 RETURN: redirect=1, redirect_pc=epc, stall_up=1; on redirect_ack: ie<=1, -> RUN.
REQ-023 redirect_ack SHALL be ignored outside VECTOR/RETURN; redirect=0 and stall_up=0 in RUN/HANDLER.
REQ-024 Saved PC arithmetic SHALL be modulo 2^32 (0xFFFFFFFC+4 = 0).
REQ-025 ERET in RUN SHALL be treated as ILLEGAL.

Reset
REQ-026 On reset=0: state=RUN, epc=0, cause=NONE, ie=1, double_fault=0.
REQ-027 During reset: rf_we=0, redirect=0, stall_up=0.
REQ-028 Reset mid-SAVE/VECTOR/RETURN SHALL abandon the sequence without redirect; after release the block is in RUN.

Structure
REQ-029 Cause codes, the ERET opcode, INTERRUPTS_ADDR (32'h0000_0080) and the state encoding SHALL be in the shared package, next to the existing opcode/funct definitions.
REQ-030 Cause/EPC/IE storage SHALL be one sub-module, cp0_regs; the FSM and writeback mux SHALL stay in fsm_step5.

Verification
REQ-031 The bench SHALL check: ADD, rd=5, data 0x1234, cause NONE, in RUN -> same-cycle rf_we=1, waddr=5, wdata=0x1234; rd=0 -> rf_we=0.
REQ-032 The bench SHALL check: SYSCALL at pc 0x40 -> SAVE: epc=0x44, cause=001, ie=0; VECTOR: redirect_pc=0x80 held 3 cycles until ack; then HANDLER.
REQ-033 The bench SHALL check: IRQ cause at pc 0x100, rd=3 -> rf_we=1 that cycle; epc=0x104; ERET in handler -> redirect_pc=0x104; after ack, ie=1 and RUN.
REQ-034 The bench SHALL check: OVERFLOW in HANDLER -> double_fault=1, epc unchanged, rf_we=0; an IRQ in HANDLER -> normal writeback.
REQ-035 The bench SHALL check: flush_step4=1 with SYSCALL -> no state change; redirect_ack pulsed in RUN -> ignored.
REQ-036 The bench SHALL check: reset=0 asserted in VECTOR -> redirect drops immediately; after release RUN, ie=1, cause=111.
